// File: rtl/led_pkg.sv
// Shared types and helpers for the LED scan driver.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  // Width of a row index; never narrower than one bit.
  function automatic int row_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Enable-gated slot/blank counter: counts 0..i_last and restarts itself on o_done.
// LED_SCAN_DIM_EN additionally exposes the top four slot bits for duty gating.
module led_scan_timer #(
  parameter int CW = 5
`ifdef LED_SCAN_DIM_EN
  , parameter int SLOT_MSB = 3
`endif
)(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_last,
  output logic          o_done
`ifdef LED_SCAN_DIM_EN
  , output logic [3:0]  o_slot_hi
`endif
);

  logic [CW-1:0] r_cnt;

  assign o_done = i_en && (r_cnt == i_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_cnt <= '0;
    else if (i_en) r_cnt <= o_done ? '0 : r_cnt + 1'b1;
  end

`ifdef LED_SCAN_DIM_EN
  assign o_slot_hi = r_cnt[SLOT_MSB -: 4];
`endif

endmodule

// File: rtl/led_scan_driver.sv
// Two-colour LED matrix row scanner driving from a shadow frame swapped at row wrap.
// LED_SCAN_DIM_EN adds a Brightness[3:0] input giving Brightness/16 drive duty.
module led_scan_driver
  import led_pkg::*;
#(
  parameter  int ROWS         = 16,
  parameter  int COLS         = 16,
  parameter  int FREQDIV      = 4,
  parameter  int BLANK_CYCLES = 2,
  localparam int RW           = row_w(ROWS)
)(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Enable,
  input  logic [ROWS-1:0][COLS-1:0]  RedPixels,
  input  logic [ROWS-1:0][COLS-1:0]  GrnPixels,
  input  logic                       FrameValid,
`ifdef LED_SCAN_DIM_EN
  input  logic [3:0]                 Brightness,
`endif
  output logic                       FrameReady,
  output logic [RW-1:0]              RowSelect,
  output logic                       RowEnable,
  output logic [COLS-1:0]            RedCols,
  output logic [COLS-1:0]            GrnCols,
  output logic                       FrameStart
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int CW = ((FREQDIV > BW) ? FREQDIV : BW) + 1;
  localparam logic [CW-1:0] DRV_LAST = CW'((1 << FREQDIV) - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_e               r_state, w_nxt;
  logic                      w_enter, w_wrap, w_tmr_en, w_done, w_drive;
  logic [CW-1:0]             w_last;
  logic [RW-1:0]             r_row, w_row_nxt;
  logic [ROWS-1:0][COLS-1:0] r_red, r_grn;
  logic                      r_ready, r_start;
`ifdef LED_SCAN_DIM_EN
  logic [3:0]                w_slot_hi, r_bright;
`endif

  assign w_tmr_en = Enable && (r_state != IDLE);
  assign w_last   = (r_state == BLANK) ? BLK_LAST : DRV_LAST;

  led_scan_timer #(
    .CW       (CW)
`ifdef LED_SCAN_DIM_EN
    , .SLOT_MSB (FREQDIV - 1)
`endif
  ) u_timer (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_en     (w_tmr_en),
    .i_last   (w_last),
    .o_done   (w_done)
`ifdef LED_SCAN_DIM_EN
    , .o_slot_hi (w_slot_hi)
`endif
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  // w_done already carries Enable, so a low Enable holds every state.
  always_comb begin
    w_nxt   = r_state;
    w_enter = 1'b0;
    case (r_state)
      IDLE:  if (Enable) begin w_nxt = DRIVE; w_enter = 1'b1; end
      DRIVE: if (w_done) begin
               if (BLANK_CYCLES == 0) begin w_nxt = DRIVE; w_enter = 1'b1; end
               else                         w_nxt = BLANK;
             end
      BLANK: if (w_done) begin w_nxt = DRIVE; w_enter = 1'b1; end
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (r_state == IDLE || r_row == RW'(ROWS - 1)) w_row_nxt = '0;
    else                                           w_row_nxt = r_row + 1'b1;
  end

  // Leaving IDLE lands on row 0, so it counts as a wrap for frame acceptance.
  assign w_wrap = w_enter && (w_row_nxt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_row   <= '0;
      r_red   <= '0;
      r_grn   <= '0;
      r_ready <= 1'b0;
      r_start <= 1'b0;
`ifdef LED_SCAN_DIM_EN
      r_bright <= '0;
`endif
    end else begin
      r_ready <= w_wrap && FrameValid;
      r_start <= w_wrap;
      if (w_enter) r_row <= w_row_nxt;
      if (w_wrap && FrameValid) begin
        r_red <= RedPixels;
        r_grn <= GrnPixels;
      end
`ifdef LED_SCAN_DIM_EN
      if (w_enter) r_bright <= Brightness;
`endif
    end
  end

`ifdef LED_SCAN_DIM_EN
  assign w_drive = (r_state == DRIVE) && (w_slot_hi < r_bright);
`else
  assign w_drive = (r_state == DRIVE);
`endif

  // Column 0 of the frame lands on the MSB of the column bus.
  always_comb begin
    RowEnable = w_drive;
    RedCols   = '0;
    GrnCols   = '0;
    for (int c = 0; c < COLS; c++) begin
      RedCols[COLS-1-c] = w_drive & r_red[r_row][c];
      GrnCols[COLS-1-c] = w_drive & r_grn[r_row][c];
    end
  end

  assign RowSelect  = r_row;
  assign FrameReady = r_ready;
  assign FrameStart = r_start;

endmodule

// File: tb/tb_led_scan_driver.sv
// Randomized bench for led_scan_driver against a position-in-row scan model.
module tb_led_scan_driver;

  localparam int ROWS = 16, COLS = 16, F = 4, B = 2;
  localparam int DRV = 1 << F, P = DRV + B;

  logic CLK = 1'b0, RST = 1'b0, Enable = 1'b0, FrameValid = 1'b0;
  logic [ROWS-1:0][COLS-1:0] RedPixels = '0, GrnPixels = '0;
`ifdef LED_SCAN_DIM_EN
  logic [3:0] Brightness = 4'd4;
`endif
  logic FrameReady, RowEnable, FrameStart;
  logic [3:0] RowSelect;
  logic [COLS-1:0] RedCols, GrnCols;

  led_scan_driver #(.ROWS(ROWS), .COLS(COLS), .FREQDIV(F), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable),
    .RedPixels(RedPixels), .GrnPixels(GrnPixels), .FrameValid(FrameValid),
`ifdef LED_SCAN_DIM_EN
    .Brightness(Brightness),
`endif
    .FrameReady(FrameReady), .RowSelect(RowSelect), .RowEnable(RowEnable),
    .RedCols(RedCols), .GrnCols(GrnCols), .FrameStart(FrameStart)
  );

  always #5 CLK = ~CLK;

  // Model: a row is P enabled cycles, the first DRV of which drive columns.
  bit              m_started, m_ready, m_start;
  int              m_row, m_pos, m_bright;
  logic [COLS-1:0] m_red [ROWS];
  logic [COLS-1:0] m_grn [ROWS];
  int              n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t row=%0d pos=%0d)", tag, obs, exp, $time, m_row, m_pos);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_ready = 0; m_start = 0;
    m_row = 0; m_pos = 0; m_bright = 0;
    for (int r = 0; r < ROWS; r++) begin m_red[r] = '0; m_grn[r] = '0; end
  endtask

  task automatic model_step();
    bit entered;
    m_ready = 0; m_start = 0; entered = 0;
    if (!Enable) return;
    if (!m_started) begin
      m_started = 1; m_row = 0; m_pos = 0; entered = 1;
    end else begin
      m_pos++;
      if (m_pos == P) begin m_pos = 0; m_row = (m_row + 1) % ROWS; entered = 1; end
    end
    if (entered && m_row == 0) begin
      m_start = 1;
      if (FrameValid) begin
        m_ready = 1;
        for (int r = 0; r < ROWS; r++) begin m_red[r] = RedPixels[r]; m_grn[r] = GrnPixels[r]; end
      end
    end
`ifdef LED_SCAN_DIM_EN
    if (entered) m_bright = int'(Brightness);
`endif
  endtask

  task automatic check_outputs();
    bit              en;
    logic [COLS-1:0] er, eg;
    en = m_started && (m_pos < DRV);
`ifdef LED_SCAN_DIM_EN
    en = en && ((m_pos >> (F - 4)) < m_bright);
`endif
    er = '0; eg = '0;
    for (int c = 0; c < COLS; c++) begin
      er[COLS-1-c] = en & m_red[m_row][c];
      eg[COLS-1-c] = en & m_grn[m_row][c];
    end
    chk("RowSelect",  64'(RowSelect),  64'(m_row));
    chk("RowEnable",  64'(RowEnable),  64'(en));
    chk("RedCols",    64'(RedCols),    64'(er));
    chk("GrnCols",    64'(GrnCols),    64'(eg));
    chk("FrameReady", 64'(FrameReady), 64'(m_ready));
    chk("FrameStart", 64'(FrameStart), 64'(m_start));
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RST) model_step();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic rand_frame();
    for (int r = 0; r < ROWS; r++) begin
      RedPixels[r] = COLS'($urandom);
      GrnPixels[r] = COLS'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_RowEnable"},  64'(RowEnable),  64'(0));
    chk({tag, "_RowSelect"},  64'(RowSelect),  64'(0));
    chk({tag, "_RedCols"},    64'(RedCols),    64'(0));
    chk({tag, "_GrnCols"},    64'(GrnCols),    64'(0));
    chk({tag, "_FrameReady"}, 64'(FrameReady), 64'(0));
    chk({tag, "_FrameStart"}, 64'(FrameStart), 64'(0));
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    check_zero("reset");

    // Single red pixel at row 1 column 1 offered before the first enable.
    RedPixels[1][1] = 1'b1;
    FrameValid = 1'b1;
    @(negedge CLK); RST = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    Enable = 1'b1;
    cycle();
    chk("first_accept", 64'({FrameReady, FrameStart}), 64'(2'b11));
    FrameValid = 1'b0;
    k = 0;
    while (!(m_row == 1 && m_pos == 0) && k < 100) begin cycle(); k++; end
    chk("row1_red", 64'(RedCols), 64'(16'h4000));
    for (int i = 0; i < 2 * ROWS * P; i++) cycle();

    // New frame content without FrameValid must not reach the columns.
    rand_frame();
    for (int i = 0; i < ROWS * P / 2; i++) cycle();
    FrameValid = 1'b1;
    k = 0;
    while (!FrameReady && k < 2 * ROWS * P) begin cycle(); k++; end
    chk("accept_wait", 64'(k < 2 * ROWS * P), 64'(1));
    FrameValid = 1'b0;

    // Pause mid-DRIVE in row 5.
    k = 0;
    while (!(m_row == 5 && m_pos == 7) && k < 2 * ROWS * P) begin cycle(); k++; end
    chk("row5_wait", 64'(k < 2 * ROWS * P), 64'(1));
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    Enable = 1'b1;
    for (int i = 0; i < 2 * P; i++) cycle();

    // Asynchronous reset during row 9 BLANK.
    k = 0;
    while (!(m_row == 9 && m_pos == DRV) && k < 2 * ROWS * P) begin cycle(); k++; end
    chk("row9_wait", 64'(k < 2 * ROWS * P), 64'(1));
    #2 RST = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    FrameValid = 1'b0;
    cycle(); cycle();
    RST = 1'b1;
    for (int i = 0; i < ROWS * P + 5; i++) cycle();

    // Randomized run: gated enable, sporadic frames, brightness changes.
    for (int i = 0; i < 4000; i++) begin
      Enable = ($urandom_range(0, 9) != 0);
      if (FrameReady) FrameValid = 1'b0;
      else if (!FrameValid && $urandom_range(0, 199) == 0) begin rand_frame(); FrameValid = 1'b1; end
      if (!FrameValid && $urandom_range(0, 49) == 0) rand_frame();
`ifdef LED_SCAN_DIM_EN
      if ($urandom_range(0, 99) == 0) Brightness = 4'($urandom);
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
